// File: rtl/shifter_4bit_if.sv
// Bus bundle for shifter_4bit: parallel load word, load select, serial in, register out.
// The optional serial-out bit is present only when SHIFTER_4BIT_SOUT_EN is defined.
// master drives the controls and observes Q; slave is the shift register itself.
interface shifter_4bit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] R;     // parallel load data
    logic             L;     // 1 = parallel load, 0 = shift right
    logic             w;     // serial data in, enters the MSB
    logic [WIDTH-1:0] Q;     // register contents
`ifdef SHIFTER_4BIT_SOUT_EN
    logic             sout;  // bit shifted out, registered

    modport master (output R, output L, output w, input Q, input sout);
    modport slave  (input R, input L, input w, output Q, output sout);
`else
    modport master (output R, output L, output w, input Q);
    modport slave  (input R, input L, input w, output Q);
`endif
endinterface

// File: rtl/shifter_4bit.sv
// Parallel-load / serial-in right shift register, WIDTH bits (default 4); optional
// registered serial output enabled by defining SHIFTER_4BIT_SOUT_EN.
// Latency: one clock from sampled inputs to Q; no backpressure, acts on every edge.
module shifter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    shifter_4bit_if.slave     bus
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next_q;

    // Next-state select: load wins over shift; reset is applied in the flop block.
    always_comb begin
        w_next_q = r_q;
        if (bus.L) begin
            w_next_q = bus.R;
        end else begin
            w_next_q = {bus.w, r_q[WIDTH-1:1]};
        end
    end

    // Main register with synchronous active-high clear taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next_q;
        end
    end

    assign bus.Q = r_q;

`ifdef SHIFTER_4BIT_SOUT_EN
    logic r_sout;

    // Serial out captures the LSB leaving the register on a shift; load and reset clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sout <= 1'b0;
        end else if (bus.L) begin
            r_sout <= 1'b0;
        end else begin
            r_sout <= r_q[0];
        end
    end

    assign bus.sout = r_sout;
`endif

endmodule

// File: tb/tb_shifter_4bit.sv
// Directed bench for shifter_4bit: reset, load, shift with w=0/1, reset/load
// collision, mid-shift reset, back-to-back loads, and serial out when enabled.
module tb_shifter_4bit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shifter_4bit_if #(.WIDTH(4)) bus ();

    shifter_4bit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then advance one rising edge and settle 1 time unit past it.
    task automatic drive_step(input logic r_in, input logic l_in, input logic w_in,
                              input logic [3:0] data);
        rst   = r_in;
        bus.L = l_in;
        bus.w = w_in;
        bus.R = data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_step(1'b1, 1'b1, 1'b1, 4'b1111);
        checks++;
        if (bus.Q !== 4'b0000) begin
            errors++;
            $display("FAIL reset_q: got %b expected %b", bus.Q, 4'b0000);
        end
`ifdef SHIFTER_4BIT_SOUT_EN
        checks++;
        if (bus.sout !== 1'b0) begin
            errors++;
            $display("FAIL reset_sout: got %b expected %b", bus.sout, 1'b0);
        end
`endif
    endtask

    task automatic test_shift_zero_short();
        logic [3:0] exp_q [4];
        exp_q = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
        drive_step(1'b0, 1'b1, 1'b0, 4'b0011);
        checks++;
        if (bus.Q !== exp_q[0]) begin
            errors++;
            $display("FAIL shift0011_load: got %b expected %b", bus.Q, exp_q[0]);
        end
        for (int i = 1; i < 4; i++) begin
            drive_step(1'b0, 1'b0, 1'b0, 4'b1100);
            checks++;
            if (bus.Q !== exp_q[i]) begin
                errors++;
                $display("FAIL shift0011_step%0d: got %b expected %b", i, bus.Q, exp_q[i]);
            end
        end
    endtask

    task automatic test_shift_zero_full();
        logic [3:0] exp_q [5];
        exp_q = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        drive_step(1'b0, 1'b1, 1'b0, 4'b1111);
        checks++;
        if (bus.Q !== exp_q[0]) begin
            errors++;
            $display("FAIL shift1111_load: got %b expected %b", bus.Q, exp_q[0]);
        end
        for (int i = 1; i < 5; i++) begin
            drive_step(1'b0, 1'b0, 1'b0, 4'b0000);
            checks++;
            if (bus.Q !== exp_q[i]) begin
                errors++;
                $display("FAIL shift1111_step%0d: got %b expected %b", i, bus.Q, exp_q[i]);
            end
        end
    endtask

    task automatic test_shift_one();
        logic [3:0] exp_q [5];
        exp_q = '{4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111};
        drive_step(1'b0, 1'b1, 1'b0, 4'b0101);
        checks++;
        if (bus.Q !== exp_q[0]) begin
            errors++;
            $display("FAIL shift0101_load: got %b expected %b", bus.Q, exp_q[0]);
        end
        for (int i = 1; i < 5; i++) begin
            drive_step(1'b0, 1'b0, 1'b1, 4'b0000);
            checks++;
            if (bus.Q !== exp_q[i]) begin
                errors++;
                $display("FAIL shift0101_step%0d: got %b expected %b", i, bus.Q, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_vs_load();
        drive_step(1'b0, 1'b1, 1'b0, 4'b0110);
        drive_step(1'b1, 1'b1, 1'b0, 4'b1010);
        checks++;
        if (bus.Q !== 4'b0000) begin
            errors++;
            $display("FAIL rst_beats_load: got %b expected %b", bus.Q, 4'b0000);
        end
        drive_step(1'b0, 1'b1, 1'b0, 4'b1010);
        checks++;
        if (bus.Q !== 4'b1010) begin
            errors++;
            $display("FAIL load_after_rst: got %b expected %b", bus.Q, 4'b1010);
        end
    endtask

    task automatic test_mid_shift_reset();
        drive_step(1'b0, 1'b1, 1'b0, 4'b1011);
        drive_step(1'b0, 1'b0, 1'b1, 4'b0000);
        checks++;
        if (bus.Q !== 4'b1101) begin
            errors++;
            $display("FAIL midrst_pre: got %b expected %b", bus.Q, 4'b1101);
        end
        drive_step(1'b1, 1'b0, 1'b1, 4'b0000);
        checks++;
        if (bus.Q !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_clear: got %b expected %b", bus.Q, 4'b0000);
        end
        drive_step(1'b0, 1'b0, 1'b1, 4'b0000);
        checks++;
        if (bus.Q !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_resume: got %b expected %b", bus.Q, 4'b1000);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [4];
        vals = '{4'b1001, 4'b0110, 4'b1110, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            drive_step(1'b0, 1'b1, ~vals[i][0], vals[i]);
            checks++;
            if (bus.Q !== vals[i]) begin
                errors++;
                $display("FAIL b2b_load%0d: got %b expected %b", i, bus.Q, vals[i]);
            end
        end
    endtask

`ifdef SHIFTER_4BIT_SOUT_EN
    task automatic test_sout();
        logic       exp_s [5];
        logic [3:0] exp_q [5];
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_q = '{4'b1001, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
        drive_step(1'b0, 1'b1, 1'b0, 4'b1001);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) drive_step(1'b0, 1'b0, 1'b0, 4'b0000);
            checks++;
            if (bus.sout !== exp_s[i]) begin
                errors++;
                $display("FAIL sout_step%0d: got %b expected %b", i, bus.sout, exp_s[i]);
            end
            checks++;
            if (bus.Q !== exp_q[i]) begin
                errors++;
                $display("FAIL sout_q_step%0d: got %b expected %b", i, bus.Q, exp_q[i]);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.L  = 1'b0;
        bus.w  = 1'b0;
        bus.R  = 4'b0000;
        #2;
        test_reset();
        test_shift_zero_short();
        test_shift_zero_full();
        test_shift_one();
        test_reset_vs_load();
        test_mid_shift_reset();
        test_back_to_back();
`ifdef SHIFTER_4BIT_SOUT_EN
        test_sout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
